hot_tracker: RTL and testbench
==============================

HOT_TRACKER -- requirements
Module: hot_tracker

Interface
REQ-001 Parameter ADDR_SIZE, 21, page address width.
REQ-002 Parameter CNT_SIZE, 12, per-entry access counter width.
REQ-003 Parameter INDEX_BITS, 8, log2 of table entries (direct-mapped, index = acc_addr[INDEX_BITS-1:0], tag = remaining upper bits).
REQ-004 Parameter EPOCH_CYCLES, 1048576, IDLE cycles between automatic table clears; minimum 2.
REQ-005 clk  in  1  clock; reset rst_n, synchronous, active-low.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 acc_addr  in  ADDR_SIZE  accessed page address.
REQ-008 acc_valid  in  1  access present.
REQ-009 acc_ready  out  1  access accepted when acc_valid & acc_ready.
REQ-010 threshold  in  CNT_SIZE  hot threshold; 0 disables hot reporting.
REQ-011 clr_req  in  1  single-cycle pulse forcing an early epoch clear.
REQ-012 hot_valid  out  1  single-cycle hot-page report; no backpressure.
REQ-013 hot_addr  out  ADDR_SIZE  reported page address.
REQ-014 hot_cnt  out  CNT_SIZE  counter value at report time.
REQ-015 clr_busy  out  1  high in DRAIN and CLEAR states.

Function
REQ-016 Entry fields SHALL be valid, tag, cnt, and reported.
REQ-017 Pipeline SHALL be: S0 accept at edge T, S1 read+update+writeback in T+1, hot_valid/hot_addr/hot_cnt registered and visible in cycle T+2 for exactly one cycle.
REQ-018 Hit (valid & tag match) SHALL set cnt to cnt+1, saturating at 2^CNT_SIZE-1.
REQ-019 Miss SHALL overwrite the entry: valid=1, new tag, cnt=1, reported=0 before hot evaluation.
REQ-020 Hot event SHALL fire when threshold!=0, updated cnt >= threshold, and reported==0; reported SHALL then be set to 1.
REQ-021 Back-to-back accesses to the same index SHALL use the forwarded S1 result, never stale array data.
REQ-022 FSM states SHALL be IDLE, DRAIN, CLEAR.
REQ-023 IDLE: acc_ready=1; epoch counter increments each cycle.
REQ-024 IDLE->DRAIN when epoch counter reaches EPOCH_CYCLES-1 or clr_req=1.
REQ-025 DRAIN: acc_ready=0 for one cycle while S1 completes, then ->CLEAR.
REQ-026 CLEAR: one entry per cycle, index 0 upward, set valid=0 and reported=0; after 2^INDEX_BITS cycles ->IDLE with epoch counter=0.
REQ-027 clr_req SHALL be ignored outside IDLE.
REQ-028 A hot report from an access in S1 at DRAIN entry SHALL still be emitted.

Reset
REQ-029 Reset SHALL force state CLEAR at index 0, so the table is invalidated before the first access.
REQ-030 Reset values: acc_ready=0, hot_valid=0, hot_addr=0, hot_cnt=0, clr_busy=1, epoch counter=0, S1 valid=0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight S1 access with no hot report.

Configuration
REQ-032 Macro HOT_TRACKER_STATS_EN defined: add outputs stat_acc (32 bits, accepted accesses) and stat_hot (32 bits, hot events); both wrap at 2^32, reset to 0, and are not cleared by epochs.
REQ-033 Macro undefined: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-034 After reset, wait 256 cycles, then acc_ready=1; threshold=3 with 3 accesses to 0x00012 -> single hot_valid pulse (hot_addr=0x00012, hot_cnt=3); a 4th access produces no report.
REQ-035 Back-to-back accesses to 0x00105 on 4 consecutive cycles, threshold=4 -> hot_cnt=4, 2 cycles after the 4th acceptance.
REQ-036 Access 0x00105, then 0x00205 (same index, different tag), then 0x00105 twice, threshold=2 -> report for 0x00105 with cnt=2 after the final access.
REQ-037 Pulse clr_req, then access a previously reported page again with threshold=1 -> clr_busy high for 257 cycles, then a fresh report with cnt=1.
REQ-038 CNT_SIZE=4, threshold=15, 20 hits -> exactly one report (cnt=15) and the counter stays at 15.
REQ-039 With HOT_TRACKER_STATS_EN defined, run scenario REQ-034 -> stat_acc=4, stat_hot=1.

Source files
------------

// File: rtl/hot_tracker.sv
// rtl/hot_tracker.sv - direct-mapped page access counter that reports pages crossing a hot threshold.
// Optional statistics outputs stat_acc/stat_hot are enabled by defining HOT_TRACKER_STATS_EN.
module hot_tracker #(
  parameter int ADDR_SIZE    = 21,
  parameter int CNT_SIZE     = 12,
  parameter int INDEX_BITS   = 8,
  parameter int EPOCH_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_SIZE-1:0]  acc_addr,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic [CNT_SIZE-1:0]   threshold,
  input  logic                  clr_req,
  output logic                  hot_valid,
  output logic [ADDR_SIZE-1:0]  hot_addr,
  output logic [CNT_SIZE-1:0]   hot_cnt,
  output logic                  clr_busy
`ifdef HOT_TRACKER_STATS_EN
  ,
  output logic [31:0]           stat_acc,
  output logic [31:0]           stat_hot
`endif
);

  localparam int DEPTH   = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_SIZE - INDEX_BITS;
  localparam int EPOCH_W = $clog2(EPOCH_CYCLES);
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCH_CYCLES - 1);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [CNT_SIZE-1:0] cnt;
    logic                reported;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  entry_t mem_q [DEPTH];
  entry_t rd_q;

  state_t                 state_q;
  logic [INDEX_BITS-1:0]  clr_idx_q;
  logic [EPOCH_W-1:0]     epoch_q;
  logic                   acc_ready_q;
  logic                   clr_busy_q;

  logic                   s1_valid_q;
  logic [ADDR_SIZE-1:0]   s1_addr_q;
  logic                   wb_valid_q;
  logic [INDEX_BITS-1:0]  wb_idx_q;
  entry_t                 wb_entry_q;

  logic                   hot_valid_q;
  logic [ADDR_SIZE-1:0]   hot_addr_q;
  logic [CNT_SIZE-1:0]    hot_cnt_q;

  logic                   accept;
  logic [INDEX_BITS-1:0]  acc_idx;
  logic [INDEX_BITS-1:0]  s1_idx;
  logic [TAG_W-1:0]       s1_tag;
  entry_t                 cur;
  entry_t                 upd_d;
  logic                   hit;
  logic                   hot_fire;

  logic                   mem_we;
  logic [INDEX_BITS-1:0]  mem_widx;
  entry_t                 mem_wdata;

  assign accept  = acc_valid & acc_ready_q;
  assign acc_idx = acc_addr[INDEX_BITS-1:0];
  assign s1_idx  = s1_addr_q[INDEX_BITS-1:0];
  assign s1_tag  = s1_addr_q[ADDR_SIZE-1:INDEX_BITS];

  // The array read was taken at acceptance, one edge before the previous
  // writeback landed; substitute that writeback when it hit the same index.
  always_comb begin
    cur      = (wb_valid_q && wb_idx_q == s1_idx) ? wb_entry_q : rd_q;
    hit      = cur.valid && (cur.tag == s1_tag);
    upd_d    = '0;
    upd_d.valid = 1'b1;
    upd_d.tag   = s1_tag;
    if (hit) begin
      upd_d.cnt      = (cur.cnt == '1) ? cur.cnt : cur.cnt + 1'b1;
      upd_d.reported = cur.reported;
    end else begin
      upd_d.cnt      = CNT_SIZE'(1);
      upd_d.reported = 1'b0;
    end
    hot_fire = s1_valid_q && (threshold != '0) && (upd_d.cnt >= threshold) && !upd_d.reported;
    if (hot_fire) upd_d.reported = 1'b1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = s1_idx;
    mem_wdata = upd_d;
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = '0;
      end else if (s1_valid_q) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
    if (accept) rd_q <= mem_q[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      epoch_q     <= '0;
      acc_ready_q <= 1'b0;
      clr_busy_q  <= 1'b1;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_idx_q    <= '0;
      wb_entry_q  <= '0;
      hot_valid_q <= 1'b0;
      hot_addr_q  <= '0;
      hot_cnt_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) s1_addr_q <= acc_addr;
      wb_valid_q <= s1_valid_q;
      wb_idx_q   <= s1_idx;
      wb_entry_q <= upd_d;
      hot_valid_q <= hot_fire;
      if (hot_fire) begin
        hot_addr_q <= s1_addr_q;
        hot_cnt_q  <= upd_d.cnt;
      end
      case (state_q)
        ST_IDLE: begin
          if (clr_req || epoch_q == EPOCH_LAST) begin
            state_q     <= ST_DRAIN;
            acc_ready_q <= 1'b0;
            clr_busy_q  <= 1'b1;
          end else begin
            epoch_q <= epoch_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
        end
        ST_CLEAR: begin
          if (clr_idx_q == INDEX_BITS'(DEPTH - 1)) begin
            state_q     <= ST_IDLE;
            acc_ready_q <= 1'b1;
            clr_busy_q  <= 1'b0;
            epoch_q     <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign acc_ready = acc_ready_q;
  assign clr_busy  = clr_busy_q;
  assign hot_valid = hot_valid_q;
  assign hot_addr  = hot_addr_q;
  assign hot_cnt   = hot_cnt_q;

`ifdef HOT_TRACKER_STATS_EN
  logic [31:0] stat_acc_q;
  logic [31:0] stat_hot_q;

  // Lifetime counters: epochs deliberately leave them untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_acc_q <= '0;
      stat_hot_q <= '0;
    end else begin
      if (accept)   stat_acc_q <= stat_acc_q + 32'd1;
      if (hot_fire) stat_hot_q <= stat_hot_q + 32'd1;
    end
  end

  assign stat_acc = stat_acc_q;
  assign stat_hot = stat_hot_q;
`else
`endif

endmodule

// File: tb/tb_hot_tracker.sv
// tb/tb_hot_tracker.sv - directed vector bench for hot_tracker (default and CNT_SIZE=4 instances).
module tb_hot_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [20:0] acc_addr;
  logic        acc_valid;
  logic        acc_ready;
  logic [11:0] threshold;
  logic        clr_req;
  logic        hot_valid;
  logic [20:0] hot_addr;
  logic [11:0] hot_cnt;
  logic        clr_busy;

  logic [20:0] s_acc_addr;
  logic        s_acc_valid;
  logic        s_acc_ready;
  logic [3:0]  s_threshold;
  logic        s_clr_req;
  logic        s_hot_valid;
  logic [20:0] s_hot_addr;
  logic [3:0]  s_hot_cnt;
  logic        s_clr_busy;

`ifdef HOT_TRACKER_STATS_EN
  logic [31:0] stat_acc, stat_hot, s_stat_acc, s_stat_hot;
`endif

  hot_tracker u_dut (
    .clk(clk), .rst_n(rst_n),
    .acc_addr(acc_addr), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .threshold(threshold), .clr_req(clr_req),
    .hot_valid(hot_valid), .hot_addr(hot_addr), .hot_cnt(hot_cnt),
    .clr_busy(clr_busy)
`ifdef HOT_TRACKER_STATS_EN
    , .stat_acc(stat_acc), .stat_hot(stat_hot)
`endif
  );

  hot_tracker #(.CNT_SIZE(4), .EPOCH_CYCLES(700)) u_small (
    .clk(clk), .rst_n(rst_n),
    .acc_addr(s_acc_addr), .acc_valid(s_acc_valid), .acc_ready(s_acc_ready),
    .threshold(s_threshold), .clr_req(s_clr_req),
    .hot_valid(s_hot_valid), .hot_addr(s_hot_addr), .hot_cnt(s_hot_cnt),
    .clr_busy(s_clr_busy)
`ifdef HOT_TRACKER_STATS_EN
    , .stat_acc(s_stat_acc), .stat_hot(s_stat_hot)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [20:0] a;
    logic [11:0] th;
    logic        hv;
    logic [20:0] ha;
    logic [11:0] hc;
  } vec_t;

  vec_t vecs [30];

  initial begin
    int t_ready;
    int busy;
    int nhot;
    logic [3:0] hcnt;

    // Row i drives an access; its report (if any) is expected in row i+2.
    vecs[0]  = '{1'b1, 21'h00012, 12'd3, 1'b0, 21'h0, 12'd0};
    vecs[1]  = '{1'b1, 21'h00012, 12'd3, 1'b0, 21'h0, 12'd0};
    vecs[2]  = '{1'b1, 21'h00012, 12'd3, 1'b0, 21'h0, 12'd0};
    vecs[3]  = '{1'b1, 21'h00012, 12'd3, 1'b0, 21'h0, 12'd0};
    vecs[4]  = '{1'b0, 21'h0,     12'd3, 1'b1, 21'h00012, 12'd3};
    vecs[5]  = '{1'b0, 21'h0,     12'd3, 1'b0, 21'h0, 12'd0};
    vecs[6]  = '{1'b0, 21'h0,     12'd4, 1'b0, 21'h0, 12'd0};
    vecs[7]  = '{1'b1, 21'h00105, 12'd4, 1'b0, 21'h0, 12'd0};
    vecs[8]  = '{1'b1, 21'h00105, 12'd4, 1'b0, 21'h0, 12'd0};
    vecs[9]  = '{1'b1, 21'h00105, 12'd4, 1'b0, 21'h0, 12'd0};
    vecs[10] = '{1'b1, 21'h00105, 12'd4, 1'b0, 21'h0, 12'd0};
    vecs[11] = '{1'b0, 21'h0,     12'd4, 1'b0, 21'h0, 12'd0};
    vecs[12] = '{1'b0, 21'h0,     12'd4, 1'b1, 21'h00105, 12'd4};
    vecs[13] = '{1'b0, 21'h0,     12'd2, 1'b0, 21'h0, 12'd0};
    vecs[14] = '{1'b1, 21'h00105, 12'd2, 1'b0, 21'h0, 12'd0};
    vecs[15] = '{1'b1, 21'h00205, 12'd2, 1'b0, 21'h0, 12'd0};
    vecs[16] = '{1'b1, 21'h00105, 12'd2, 1'b0, 21'h0, 12'd0};
    vecs[17] = '{1'b1, 21'h00105, 12'd2, 1'b0, 21'h0, 12'd0};
    vecs[18] = '{1'b0, 21'h0,     12'd2, 1'b0, 21'h0, 12'd0};
    vecs[19] = '{1'b0, 21'h0,     12'd2, 1'b1, 21'h00105, 12'd2};
    vecs[20] = '{1'b0, 21'h0,     12'd0, 1'b0, 21'h0, 12'd0};
    vecs[21] = '{1'b1, 21'h00777, 12'd0, 1'b0, 21'h0, 12'd0};
    vecs[22] = '{1'b1, 21'h00777, 12'd0, 1'b0, 21'h0, 12'd0};
    vecs[23] = '{1'b0, 21'h0,     12'd0, 1'b0, 21'h0, 12'd0};
    vecs[24] = '{1'b0, 21'h0,     12'd0, 1'b0, 21'h0, 12'd0};
    vecs[25] = '{1'b0, 21'h0,     12'd0, 1'b0, 21'h0, 12'd0};
    vecs[26] = '{1'b0, 21'h0,     12'd1, 1'b0, 21'h0, 12'd0};
    vecs[27] = '{1'b1, 21'h00777, 12'd1, 1'b0, 21'h0, 12'd0};
    vecs[28] = '{1'b0, 21'h0,     12'd1, 1'b0, 21'h0, 12'd0};
    vecs[29] = '{1'b0, 21'h0,     12'd1, 1'b1, 21'h00777, 12'd3};

    rst_n = 1'b0;
    acc_addr = '0; acc_valid = 1'b0; threshold = '0; clr_req = 1'b0;
    s_acc_addr = '0; s_acc_valid = 1'b0; s_threshold = '0; s_clr_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset acc_ready", acc_ready, 0);
    check("reset hot_valid", hot_valid, 0);
    check("reset hot_addr", hot_addr, 0);
    check("reset hot_cnt", hot_cnt, 0);
    check("reset clr_busy", clr_busy, 1);
    check("reset small clr_busy", s_clr_busy, 1);
    rst_n = 1'b1;

    repeat (255) @(posedge clk);
    #1;
    check("clear 255 acc_ready", acc_ready, 0);
    check("clear 255 clr_busy", clr_busy, 1);
    @(posedge clk);
    #1;
    check("clear 256 acc_ready", acc_ready, 1);
    check("clear 256 clr_busy", clr_busy, 0);
    check("clear 256 small acc_ready", s_acc_ready, 1);
    t_ready = cyc;

    // CNT_SIZE=4: 20 hits on one page must saturate at 15 and report once.
    nhot = 0;
    hcnt = '0;
    for (int k = 0; k < 26; k++) begin
      s_acc_valid = (k < 20);
      s_acc_addr  = 21'h00042;
      s_threshold = 4'd15;
      @(posedge clk);
      #1;
      if (s_hot_valid) begin
        nhot++;
        hcnt = s_hot_cnt;
      end
    end
    s_acc_valid = 1'b0;
    check("sat report count", nhot, 1);
    check("sat report cnt", hcnt, 15);

    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("row %0d acc_ready", i), acc_ready, 1);
      check($sformatf("row %0d hot_valid", i), hot_valid, vecs[i].hv);
      if (vecs[i].hv) begin
        check($sformatf("row %0d hot_addr", i), hot_addr, vecs[i].ha);
        check($sformatf("row %0d hot_cnt", i), hot_cnt, vecs[i].hc);
      end
`ifdef HOT_TRACKER_STATS_EN
      if (i == 6) begin
        check("stat_acc", stat_acc, 4);
        check("stat_hot", stat_hot, 1);
      end
`endif
      acc_valid = vecs[i].v;
      acc_addr  = vecs[i].a;
      threshold = vecs[i].th;
    end

    // Early clear with an access accepted on the same edge: report survives the drain.
    acc_valid = 1'b1; acc_addr = 21'h00333; threshold = 12'd1; clr_req = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0; clr_req = 1'b0;
    check("drain clr_busy", clr_busy, 1);
    check("drain acc_ready", acc_ready, 0);
    busy = 1;
    @(posedge clk);
    #1;
    check("drain hot_valid", hot_valid, 1);
    check("drain hot_addr", hot_addr, 21'h00333);
    check("drain hot_cnt", hot_cnt, 1);
    if (clr_busy) busy++;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (!clr_busy) break;
      busy++;
    end
    check("clr_busy cycles", busy, 257);
    check("post clear acc_ready", acc_ready, 1);

    acc_valid = 1'b1; acc_addr = 21'h00012; threshold = 12'd1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fresh hot_valid", hot_valid, 1);
    check("fresh hot_addr", hot_addr, 21'h00012);
    check("fresh hot_cnt", hot_cnt, 1);

    // Small instance: automatic epoch clear after 700 idle cycles.
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (s_clr_busy) break;
    end
    check("epoch idle cycles", cyc - t_ready, 700);

    // Reset with an access sitting in S1 must not produce a report.
    acc_valid = 1'b1; acc_addr = 21'h00555; threshold = 12'd1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset hot_valid", hot_valid, 0);
    check("midreset acc_ready", acc_ready, 0);
    check("midreset clr_busy", clr_busy, 1);
    @(posedge clk);
    #1;
    check("midreset hot_valid late", hot_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
